// File: rtl/aos_sr_router_pkg.sv
// Shared soft-register bus types and router-local constants.
// AMITypes carries the bus structs; AOSF1Types carries router state and poison value.
package AMITypes;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

endpackage

package AOSF1Types;

  localparam logic [63:0] SR_POISON_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } sr_state_t;

endpackage

// File: rtl/aos_sr_router_if.sv
// Host-side and app-side soft-register buses of the router, bundled for hookup.
// Handshake: valid-only, no back-pressure; each request or response is a one-cycle
// valid pulse, and every other field is zero whenever valid is low.
interface aos_sr_router_if
  import AMITypes::*;
#(
  parameter int SR_NUM_APPS = 4
) ();

  logic [SR_NUM_APPS-1:0] app_enable;
  SoftRegReq              softreg_req;
  SoftRegResp             softreg_resp;
  SoftRegReq              app_softreg_req  [SR_NUM_APPS-1:0];
  SoftRegResp             app_softreg_resp [SR_NUM_APPS-1:0];

  modport master (
    output app_enable, softreg_req, app_softreg_resp,
    input  softreg_resp, app_softreg_req
  );

  modport slave (
    input  app_enable, softreg_req, app_softreg_resp,
    output softreg_resp, app_softreg_req
  );

endinterface

// File: rtl/aos_sr_router_fifo.sv
// Small circular-buffer FIFO with a fall-through head; pushes into a full FIFO are ignored.
module HullFIFO #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  output logic             full,
  input  logic             deq,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 push;
  logic                 pop;

  assign full  = (count == (LOG_DEPTH + 1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = enq && !full;
  assign pop   = deq && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{LOG_DEPTH{1'b0}}, push} - {{LOG_DEPTH{1'b0}}, pop};
    end
  end

  // Storage needs no reset: the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/aos_sr_router.sv
// Routes buffered host soft-register requests to one of several app ports by an
// address select field; one read outstanding at a time, with timeout and poison.
module aos_sr_router
  import AMITypes::*;
  import AOSF1Types::*;
#(
  parameter int SR_NUM_APPS    = 4,
  parameter int SEL_LSB        = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_LOG_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SR_NUM_APPS-1:0] app_enable,
  input  SoftRegReq              softreg_req,
  output SoftRegResp             softreg_resp,
  output SoftRegReq              app_softreg_req  [SR_NUM_APPS-1:0],
  input  SoftRegResp             app_softreg_resp [SR_NUM_APPS-1:0],
  output logic [15:0]            drop_count,
  output logic [15:0]            timeout_count,
  output sr_state_t              state
);

  localparam int          IDX_W     = (SR_NUM_APPS > 1) ? $clog2(SR_NUM_APPS) : 1;
  localparam int          EN_W      = 1 << IDX_W;
  localparam logic [31:0] LOW_MASK  = (32'd1 << SEL_LSB) - 32'd1;
  localparam logic [15:0] TMO       = 16'(TIMEOUT_CYCLES);
  localparam logic [4:0]  NUM_APPS5 = 5'(SR_NUM_APPS);

  logic [$bits(SoftRegReq)-1:0] head_bits;
  SoftRegReq                    head;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic                         pop;

  sr_state_t        state_n;
  logic [15:0]      wait_cnt, wait_cnt_n;
  logic [IDX_W-1:0] rec_idx, rec_idx_n;
  logic [IDX_W-1:0] idx;
  logic [31:0]      fwd_addr;
  logic [EN_W-1:0]  en_pad;
  logic             legal;
  logic             timeout_hit;
  SoftRegResp       cur_resp;
  SoftRegResp       resp_n;
  SoftRegReq        app_n [SR_NUM_APPS-1:0];

  HullFIFO #(
    .WIDTH     ($bits(SoftRegReq)),
    .LOG_DEPTH (FIFO_LOG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (rst_n),
    .enq      (softreg_req.valid),
    .enq_data (softreg_req),
    .full     (fifo_full),
    .deq      (pop),
    .head     (head_bits),
    .empty    (fifo_empty)
  );

  assign head     = head_bits;
  assign en_pad   = EN_W'(app_enable);
  assign cur_resp = app_softreg_resp[rec_idx];

  // Select field is squeezed out of the forwarded address; one app means no field at all.
  always_comb begin
    if (SR_NUM_APPS == 1) begin
      idx      = '0;
      fwd_addr = head.addr;
    end else begin
      idx      = head.addr[SEL_LSB +: IDX_W];
      fwd_addr = ((head.addr >> (SEL_LSB + IDX_W)) << SEL_LSB) | (head.addr & LOW_MASK);
    end
    legal = (5'(idx) < NUM_APPS5) && en_pad[idx];
  end

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    rec_idx_n   = rec_idx;
    resp_n      = '0;
    timeout_hit = 1'b0;
    pop         = 1'b0;
    for (int i = 0; i < SR_NUM_APPS; i++) app_n[i] = '0;

    case (state)
      IDLE: begin
        pop = !fifo_empty;
        if (pop && head.valid) begin
          if (legal) begin
            app_n[idx].valid   = 1'b1;
            app_n[idx].isWrite = head.isWrite;
            app_n[idx].addr    = fwd_addr;
            app_n[idx].data    = head.data;
            if (!head.isWrite) begin
              state_n    = WAIT_RESP;
              wait_cnt_n = '0;
              rec_idx_n  = idx;
            end
          end else if (!head.isWrite) begin
            resp_n.valid = 1'b1;
            resp_n.data  = SR_POISON_DATA;
          end
        end
      end
      WAIT_RESP: begin
        // A real response beats a timeout landing on the same cycle.
        if (cur_resp.valid) begin
          resp_n.valid = 1'b1;
          resp_n.data  = cur_resp.data;
          state_n      = IDLE;
        end else if (wait_cnt >= TMO) begin
          resp_n.valid = 1'b1;
          resp_n.data  = SR_POISON_DATA;
          timeout_hit  = 1'b1;
          state_n      = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      rec_idx       <= '0;
      softreg_resp  <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
      for (int i = 0; i < SR_NUM_APPS; i++) app_softreg_req[i] <= '0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_cnt_n;
      rec_idx      <= rec_idx_n;
      softreg_resp <= resp_n;
      for (int i = 0; i < SR_NUM_APPS; i++) app_softreg_req[i] <= app_n[i];
      if (softreg_req.valid && fifo_full && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (timeout_hit && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_aos_sr_router.sv
// Directed bench for aos_sr_router: latency, read forwarding, timeout, disabled apps,
// buffer overflow ordering and mid-transaction reset.
module tb_aos_sr_router;
  import AMITypes::*;
  import AOSF1Types::*;

  localparam logic [63:0] POISON = 64'hDEAD_DEAD_DEAD_DEAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] drop_count;
  logic [15:0] timeout_count;
  sr_state_t   dbg_state;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic        seen;

  always #5 clk = ~clk;

  aos_sr_router_if #(.SR_NUM_APPS(4)) bus ();

  aos_sr_router #(
    .SR_NUM_APPS    (4),
    .SEL_LSB        (3),
    .TIMEOUT_CYCLES (8),
    .FIFO_LOG_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .app_enable       (bus.app_enable),
    .softreg_req      (bus.softreg_req),
    .softreg_resp     (bus.softreg_resp),
    .app_softreg_req  (bus.app_softreg_req),
    .app_softreg_resp (bus.app_softreg_resp),
    .drop_count       (drop_count),
    .timeout_count    (timeout_count),
    .state            (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one host request for exactly one cycle; returns early in the following cycle.
  task automatic host_send(input logic wr, input logic [31:0] addr, input logic [63:0] data);
    next_cycle();
    bus.softreg_req = '{valid: 1'b1, isWrite: wr, addr: addr, data: data};
    next_cycle();
    bus.softreg_req = '0;
  endtask

  task automatic app_respond(input int i, input logic [63:0] data);
    bus.app_softreg_resp[i] = '{valid: 1'b1, data: data};
    next_cycle();
    bus.app_softreg_resp[i] = '0;
  endtask

  function automatic logic any_app_valid();
    logic v = 1'b0;
    for (int i = 0; i < 4; i++) v |= bus.app_softreg_req[i].valid;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n           = 1'b0;
    bus.softreg_req = '0;
    bus.app_enable  = 4'hF;
    for (int i = 0; i < 4; i++) bus.app_softreg_resp[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 64'(bus.softreg_resp.valid), 64'd0);
    check("rst_app_valid", 64'(any_app_valid()), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_timeout", 64'(timeout_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write 0x118 -> app 3, addr 0x40, two cycles after host valid.
    host_send(1'b1, 32'h0000_0118, 64'h0000_0000_CAFE_F00D);
    @(negedge clk);
    check("wr_lat_t1", 64'(bus.app_softreg_req[3].valid), 64'd0);
    @(negedge clk);
    check("wr_lat_t2", 64'(bus.app_softreg_req[3].valid), 64'd1);
    check("wr_addr", 64'(bus.app_softreg_req[3].addr), 64'h40);
    check("wr_data", bus.app_softreg_req[3].data, 64'h0000_0000_CAFE_F00D);
    check("wr_is_write", 64'(bus.app_softreg_req[3].isWrite), 64'd1);
    @(negedge clk);
    check("wr_pulse_end", 64'(bus.app_softreg_req[3].valid), 64'd0);
    check("wr_pulse_addr_zero", 64'(bus.app_softreg_req[3].addr), 64'd0);

    // Read 0x22D -> app 1, addr 0x8D; app answers five cycles after issue.
    host_send(1'b0, 32'h0000_022D, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("rd_issue_valid", 64'(bus.app_softreg_req[1].valid), 64'd1);
    check("rd_issue_addr", 64'(bus.app_softreg_req[1].addr), 64'h8D);
    check("rd_issue_is_write", 64'(bus.app_softreg_req[1].isWrite), 64'd0);
    check("rd_state_wait", 64'(dbg_state), 64'(WAIT_RESP));
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 5) bus.app_softreg_resp[1] = '{valid: 1'b1, data: 64'h1234};
    end
    @(negedge clk);
    check("rd_no_early_resp", 64'(bus.softreg_resp.valid), 64'd0);
    next_cycle();
    bus.app_softreg_resp[1] = '0;
    @(negedge clk);
    check("rd_resp_valid", 64'(bus.softreg_resp.valid), 64'd1);
    check("rd_resp_data", bus.softreg_resp.data, 64'h1234);
    check("rd_state_idle", 64'(dbg_state), 64'(IDLE));

    // Read 0x10 -> app 2 which never answers; poison nine cycles after issue.
    host_send(1'b0, 32'h0000_0010, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("to_issue_valid", 64'(bus.app_softreg_req[2].valid), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) check("to_not_yet", 64'(bus.softreg_resp.valid), 64'd0);
    end
    check("to_poison_valid", 64'(bus.softreg_resp.valid), 64'd1);
    check("to_poison_data", bus.softreg_resp.data, POISON);
    check("to_count", 64'(timeout_count), 64'd1);
    next_cycle();
    app_respond(2, 64'h5555);
    @(negedge clk);
    check("to_late_discarded", 64'(bus.softreg_resp.valid), 64'd0);
    check("to_late_state", 64'(dbg_state), 64'(IDLE));

    // App 2 disabled: read gets poison with no app traffic, write vanishes.
    bus.app_enable = 4'b1011;
    host_send(1'b0, 32'h0000_0010, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("dis_rd_poison_valid", 64'(bus.softreg_resp.valid), 64'd1);
    check("dis_rd_poison_data", bus.softreg_resp.data, POISON);
    check("dis_rd_no_app", 64'(any_app_valid()), 64'd0);
    check("dis_rd_state", 64'(dbg_state), 64'(IDLE));
    host_send(1'b1, 32'h0000_0010, 64'h77);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= any_app_valid() | bus.softreg_resp.valid;
    end
    check("dis_wr_silent", 64'(seen), 64'd0);
    bus.app_enable = 4'hF;

    // Read outstanding on app 0, then six back-to-back writes to app 3: four fit.
    host_send(1'b0, 32'h0000_0004, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("ovf_rd_issue", 64'(bus.app_softreg_req[0].valid), 64'd1);
    check("ovf_rd_addr", 64'(bus.app_softreg_req[0].addr), 64'h4);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      bus.softreg_req = '{valid: 1'b1, isWrite: 1'b1, addr: 32'h18 | (32'(k) << 5), data: 64'(k)};
      if (k < 4) exp_q.push_back(64'(k));
    end
    next_cycle();
    bus.softreg_req = '0;
    @(negedge clk);
    check("ovf_drop_count", 64'(drop_count), 64'd2);
    check("ovf_writes_held", 64'(bus.app_softreg_req[3].valid), 64'd0);
    next_cycle();
    app_respond(0, 64'hBEEF);
    @(negedge clk);
    check("ovf_rd_resp", bus.softreg_resp.data, 64'hBEEF);
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.app_softreg_req[3].valid) begin
        e = exp_q.pop_front();
        check("ovf_order_data", bus.app_softreg_req[3].data, e);
        check("ovf_order_addr", 64'(bus.app_softreg_req[3].addr), {e[60:0], 3'b000});
      end
    end
    check("ovf_all_delivered", 64'(exp_q.size()), 64'd0);

    // Reset while a read to app 1 is outstanding.
    host_send(1'b0, 32'h0000_0008, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_issue", 64'(bus.app_softreg_req[1].valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_app_valid", 64'(bus.app_softreg_req[1].valid), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    check("rst_mid_drop", 64'(drop_count), 64'd0);
    check("rst_mid_timeout", 64'(timeout_count), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    app_respond(1, 64'h77);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.softreg_resp.valid;
    end
    check("rst_mid_no_resp", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aos_sr_router.md
AOS_SR_ROUTER -- requirements
Module: aos_sr_router

Interface
REQ-001 SHALL have parameter SR_NUM_APPS, default 4, number of app ports (legal range 1..16).
REQ-002 SHALL have parameter SEL_LSB, default 3, lowest host address bit of the app-select field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, read-response wait limit in cycles (legal range 2..65535).
REQ-004 SHALL have parameter FIFO_LOG_DEPTH, default 2, log2 depth of the host request buffer.
REQ-005 SHALL define IDX_W = max(1, clog2(SR_NUM_APPS)), the select-field width.
REQ-006 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port app_enable[SR_NUM_APPS-1:0], input, 1 each, app slot is live.
REQ-009 SHALL have port softreg_req, input, SoftRegReq, host request (valid, isWrite, addr 32, data 64).
REQ-010 SHALL have port softreg_resp, output, SoftRegResp, host response (valid, data 64).
REQ-011 SHALL have port app_softreg_req[SR_NUM_APPS-1:0], output, SoftRegReq, per-app request.
REQ-012 SHALL have port app_softreg_resp[SR_NUM_APPS-1:0], input, SoftRegResp, per-app response.
REQ-013 SHALL have port drop_count, output, 16, saturating count of host requests lost to a full buffer.
REQ-014 SHALL have port timeout_count, output, 16, saturating count of read timeouts.

Function
REQ-015 SHALL write a host request with valid=1 into the request FIFO when the FIFO is not full; when full, the request is dropped and drop_count increments, saturating at 16'hFFFF.
REQ-016 SHALL decode target index idx = addr[SEL_LSB+IDX_W-1:SEL_LSB].
REQ-017 SHALL forward to the app the address {IDX_W'b0, addr[31:SEL_LSB+IDX_W], addr[SEL_LSB-1:0]}, with isWrite and data unchanged.
REQ-018 SHALL register all outputs; each app_softreg_req and softreg_resp is a one-cycle valid pulse with other fields zero when not valid.
REQ-019 SHALL use a state machine with states IDLE and WAIT_RESP; it pops the FIFO head only in IDLE, at most one entry per cycle.
REQ-020 SHALL, in IDLE, pop a write to an enabled idx < SR_NUM_APPS and pulse it to that app the next cycle, staying in IDLE.
REQ-021 SHALL, in IDLE, pop a read to an enabled idx < SR_NUM_APPS, pulse it to that app, load the wait counter with 0, record idx, and enter WAIT_RESP.
REQ-022 SHALL give zero-load latency of host valid at cycle T to app valid at cycle T+2.
REQ-023 SHALL silently discard a write to a disabled idx or to idx >= SR_NUM_APPS.
REQ-024 SHALL answer a read to a disabled idx or to idx >= SR_NUM_APPS with softreg_resp data SR_POISON_DATA on the cycle after the pop, staying in IDLE.
REQ-025 SHALL, in WAIT_RESP, forward a valid response from the recorded app to softreg_resp on the next cycle and return to IDLE.
REQ-026 SHALL, in WAIT_RESP, increment the wait counter each cycle; on reaching TIMEOUT_CYCLES with no response, emit SR_POISON_DATA next cycle, increment timeout_count (saturating), and return to IDLE.
REQ-027 SHALL let a real response win when it arrives in the same cycle the counter reaches TIMEOUT_CYCLES; no timeout is then counted.
REQ-028 SHALL discard app responses that arrive from a non-recorded app, or in IDLE (for example late responses after a timeout).
REQ-029 SHALL hold writes queued behind an outstanding read in the FIFO, preserving host order.
REQ-030 SHALL, when SR_NUM_APPS == 1, skip the address compaction and route every request to port 0 while keeping the timeout and poison behaviour.

Reset
REQ-031 SHALL, on rst_n low, asynchronously set state to IDLE, flush the FIFO, zero all counters, drive all output valid and field bits to 0, and clear the recorded idx.
REQ-032 SHALL not emit a response for a read that was outstanding at reset; a response arriving after reset release is discarded per REQ-028.

Structure
REQ-033 SHALL place SR_POISON_DATA (64'hDEAD_DEAD_DEAD_DEAD) and the state enum typedef in package AOSF1Types; SoftRegReq and SoftRegResp come from AMITypes.
REQ-034 SHALL use one HullFIFO instance (WIDTH = bits of SoftRegReq, LOG_DEPTH = FIFO_LOG_DEPTH, reset_n = rst_n) as the only sub-module.

Verification
REQ-035 SHALL cover: N=4, SEL_LSB=3, write addr 0x0000_0118, all apps enabled -> app 3 valid at T+2, addr 0x0000_0040.
REQ-036 SHALL cover: read idx 1, app 1 responds data 0x1234 five cycles after issue -> softreg_resp 0x1234 one cycle later, state IDLE.
REQ-037 SHALL cover: TIMEOUT_CYCLES=8, app never responds -> poison at issue+9, timeout_count=1; a later app response is discarded.
REQ-038 SHALL cover: app_enable[2]=0, read idx 2 -> poison response, no app 2 valid; write idx 2 -> nothing emitted.
REQ-039 SHALL cover: FIFO_LOG_DEPTH=2, read outstanding, 6 back-to-back writes -> 4 buffered and delivered in order after the response, drop_count=2.
REQ-040 SHALL cover: rst_n pulsed low mid WAIT_RESP -> outputs 0 immediately, no response emitted, counters 0.
